// File: rtl/display_scan_ctrl_if.sv
// Display scan bus: scan control and display value in, digit index and cathode drive out.
interface display_scan_ctrl_if;
    logic        enable;
    logic [31:0] value;
    logic        load;
    logic [2:0]  count;
    logic        blank;
    logic [6:0]  segments;
    logic        dp;
    logic        frame_done;

    modport master (
        output enable, value, load,
        input  count, blank, segments, dp, frame_done
    );

    modport slave (
        input  enable, value, load,
        output count, blank, segments, dp, frame_done
    );
endinterface

// File: rtl/display_scan_ctrl.sv
// 8-digit hex display scanner with a blanking gap between digits and a double-buffered
// display value. A new value only takes effect at a frame boundary (digit 7 -> 0) or on
// entry from idle, so a frame is never torn.
module display_scan_ctrl #(
    parameter int unsigned COUNT_MAX    = 100000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter logic [7:0]  DP_MASK      = 8'h00
) (
    input logic              clk,
    input logic              reset,
    display_scan_ctrl_if.slave bus
);

    localparam int unsigned PW = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
    localparam int unsigned BW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [PW-1:0] PrescLast = PW'(COUNT_MAX - 1);
    localparam logic [BW-1:0] BlankLast = (BLANK_CYCLES > 0) ? BW'(BLANK_CYCLES - 1) : '0;

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic [2:0]    count_q, count_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [31:0]   pending_q, pending_d;
    logic          pv_q, pv_d;
    logic          blank_q, blank_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          fd_q, fd_d;
    logic          step;
    logic          boundary;
    logic [3:0]    nib;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Next-state: scan sequencing, buffer management, and the output values for the next cycle.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        bcnt_d    = bcnt_q;
        count_d   = count_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        pv_d      = pv_q;
        step      = 1'b0;
        boundary  = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.enable) begin
                    state_d  = StShow;
                    presc_d  = '0;
                    count_d  = 3'd0;
                    // Leaving idle starts a fresh frame, so pending data is applied here.
                    boundary = 1'b1;
                end
            end
            StShow: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    presc_d = '0;
                    bcnt_d  = '0;
                    count_d = 3'd0;
                end else if (presc_q == PrescLast) begin
                    presc_d = '0;
                    if (BLANK_CYCLES > 0) begin
                        state_d = StBlank;
                        bcnt_d  = '0;
                    end else begin
                        step = 1'b1;
                    end
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            StBlank: begin
                if (!bus.enable) begin
                    state_d = StIdle;
                    presc_d = '0;
                    bcnt_d  = '0;
                    count_d = 3'd0;
                end else if (bcnt_q == BlankLast) begin
                    state_d = StShow;
                    bcnt_d  = '0;
                    step    = 1'b1;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (step) begin
            count_d  = count_q + 3'd1;
            boundary = (count_q == 3'd7);
        end

        if (boundary) begin
            // A load in the boundary cycle bypasses the pending buffer.
            if (bus.load) begin
                shadow_d = bus.value;
                pv_d     = 1'b0;
            end else if (pv_q) begin
                shadow_d = pending_q;
                pv_d     = 1'b0;
            end
        end else if (bus.load) begin
            if (state_q == StIdle) begin
                // Nothing is lit in idle, so the value can go straight to the shadow.
                shadow_d = bus.value;
                pv_d     = 1'b0;
            end else begin
                pending_d = bus.value;
                pv_d      = 1'b1;
            end
        end

        nib     = shadow_d[{count_d, 2'b00} +: 4];
        blank_d = (state_d != StShow);
        seg_d   = (state_d == StShow) ? hex7(nib) : 7'h7F;
        dp_d    = (state_d == StShow) ? ~DP_MASK[count_d] : 1'b1;
        // Flag the cycle whose closing edge wraps the digit index 7 -> 0.
        fd_d    = (count_d == 3'd7) &&
                  (((state_d == StShow) && (presc_d == PrescLast) && (BLANK_CYCLES == 0)) ||
                   ((state_d == StBlank) && (bcnt_d == BlankLast)));
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            presc_q   <= '0;
            bcnt_q    <= '0;
            count_q   <= 3'd0;
            shadow_q  <= '0;
            pending_q <= '0;
            pv_q      <= 1'b0;
            blank_q   <= 1'b1;
            seg_q     <= 7'h7F;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            bcnt_q    <= bcnt_d;
            count_q   <= count_d;
            shadow_q  <= shadow_d;
            pending_q <= pending_d;
            pv_q      <= pv_d;
            blank_q   <= blank_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.count      = count_q;
    assign bus.blank      = blank_q;
    assign bus.segments   = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed bench for display_scan_ctrl: scan timing, blanking, tear-free buffering, bypass
// load, disable/re-enable, async reset, and a no-blank-gap instance.
module tb_display_scan_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    display_scan_ctrl_if bus ();
    display_scan_ctrl_if bus2 ();

    display_scan_ctrl #(
        .COUNT_MAX   (4),
        .BLANK_CYCLES(2),
        .DP_MASK     (8'h04)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    display_scan_ctrl #(
        .COUNT_MAX   (4),
        .BLANK_CYCLES(0),
        .DP_MASK     (8'h04)
    ) dut2 (
        .clk  (clk),
        .reset(reset),
        .bus  (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Active-low hex patterns {g,f,e,d,c,b,a}, copied from the decode table.
    function automatic logic [6:0] seg_ref(input logic [3:0] n);
        logic [6:0] t [16];
        t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
        return t[n];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One digit period (4 SHOW + 2 BLANK), checking every cycle; optional load at cycle lcyc.
    task automatic digit(input int d, input logic [3:0] nib, input int lcyc,
                         input logic [31:0] lval);
        for (int c = 0; c < 6; c++) begin
            if (c == lcyc) begin
                bus.load  = 1'b1;
                bus.value = lval;
            end
            chk("count", {29'd0, bus.count}, d);
            chk("blank", {31'd0, bus.blank}, (c >= 4) ? 1 : 0);
            chk("seg", {25'd0, bus.segments}, (c < 4) ? {25'd0, seg_ref(nib)} : 32'h7F);
            chk("dp", {31'd0, bus.dp}, (c < 4 && d == 2) ? 0 : 1);
            chk("frame_done", {31'd0, bus.frame_done}, (d == 7 && c == 5) ? 1 : 0);
            tick();
            bus.load = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] v;
        checks      = 0;
        failures    = 0;
        reset       = 1'b0;
        bus.enable  = 1'b0;
        bus.load    = 1'b0;
        bus.value   = '0;
        bus2.enable = 1'b0;
        bus2.load   = 1'b0;
        bus2.value  = '0;
        tick();
        tick();
        chk("rst_count", {29'd0, bus.count}, 0);
        chk("rst_blank", {31'd0, bus.blank}, 1);
        chk("rst_seg", {25'd0, bus.segments}, 32'h7F);
        chk("rst_dp", {31'd0, bus.dp}, 1);
        chk("rst_fd", {31'd0, bus.frame_done}, 0);
        reset = 1'b1;
        tick();

        // Load while idle goes straight to the shadow.
        bus.load  = 1'b1;
        bus.value = 32'h76543210;
        tick();
        bus.load = 1'b0;
        chk("idle_blank", {31'd0, bus.blank}, 1);
        bus.enable = 1'b1;
        tick();

        // Frame 1: digit d shows nibble d.
        for (int d = 0; d < 8; d++) digit(d, 4'(d), -1, '0);
        // Frame 2: pending load at digit 3 must not tear this frame.
        for (int d = 0; d < 8; d++) digit(d, 4'(d), (d == 3) ? 0 : -1, 32'hFFFFFFFF);
        // Frame 3: all F; two loads, the later one wins.
        for (int d = 0; d < 8; d++) begin
            v = (d == 3) ? 32'h11111111 : 32'hAAAAAAAA;
            digit(d, 4'hF, (d == 3 || d == 5) ? 0 : -1, v);
        end
        // Frame 4: all A; load coincident with frame_done bypasses to the shadow.
        for (int d = 0; d < 8; d++) digit(d, 4'hA, (d == 7) ? 5 : -1, 32'h88888888);
        // Frame 5: all 8; pending load at digit 1, then disable at digit 5.
        for (int d = 0; d < 5; d++) digit(d, 4'h8, (d == 1) ? 0 : -1, 32'h01234567);
        chk("pre_dis_count", {29'd0, bus.count}, 5);
        bus.enable = 1'b0;
        tick();
        chk("dis_count", {29'd0, bus.count}, 0);
        chk("dis_blank", {31'd0, bus.blank}, 1);
        chk("dis_seg", {25'd0, bus.segments}, 32'h7F);
        chk("dis_dp", {31'd0, bus.dp}, 1);
        chk("dis_fd", {31'd0, bus.frame_done}, 0);
        tick();
        chk("idle_fd", {31'd0, bus.frame_done}, 0);
        bus.enable = 1'b1;
        tick();
        // Re-entry shows the pending value from digit 0; nibble d = 7-d.
        for (int d = 0; d < 8; d++) digit(d, 4'(7 - d), -1, '0);
        digit(0, 4'h7, -1, '0);
        digit(1, 4'h6, -1, '0);

        // Async reset in the middle of a SHOW cycle of digit 2.
        chk("pre_rst_count", {29'd0, bus.count}, 2);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", {29'd0, bus.count}, 0);
        chk("arst_blank", {31'd0, bus.blank}, 1);
        chk("arst_seg", {25'd0, bus.segments}, 32'h7F);
        chk("arst_dp", {31'd0, bus.dp}, 1);
        chk("arst_fd", {31'd0, bus.frame_done}, 0);
        #1;
        reset      = 1'b1;
        bus.enable = 1'b0;
        tick();

        // No-gap instance: 4 cycles per digit, never blank, shadow is 0 after reset.
        bus2.enable = 1'b1;
        tick();
        for (int i = 0; i < 36; i++) begin
            chk("ng_count", {29'd0, bus2.count}, (i / 4) % 8);
            chk("ng_blank", {31'd0, bus2.blank}, 0);
            chk("ng_seg", {25'd0, bus2.segments}, 32'h40);
            chk("ng_fd", {31'd0, bus2.frame_done}, (i % 32 == 31) ? 1 : 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
